// File: rtl/arm_mem_nport.sv
`default_nettype none
// ============================================================================
// Module   : arm_mem_nport
// Purpose  : N-port word memory with byte enables, registered acknowledged
//            reads, per-port exception codes, priority write-collision
//            arbitration and a post-reset clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module arm_mem_nport #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*32-1:0]     wdata,
  input  logic [NPORTS*4-1:0]      be,
  output logic                     ready,
  output logic [NPORTS-1:0]        ack,
  output logic [NPORTS*32-1:0]     rdata,
  output logic [NPORTS-1:0]        excpt,
  output logic [NPORTS*2-1:0]      excpt_code
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_iw = ADDR_W - 2;
  // DEPTH widened by one bit so the range compare works even when DEPTH
  // covers the whole word-index space.
  localparam logic [c_iw:0]   c_depth = (c_iw + 1)'(DEPTH);
  localparam logic [c_aw-1:0] c_last  = c_aw'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic   [c_aw-1:0]           r_cnt;
  logic   [31:0]               r_mem [DEPTH];
  logic                        w_clear;
  logic   [NPORTS-1:0][c_iw-1:0] w_widx_full;
  logic   [NPORTS-1:0][c_aw-1:0] w_widx;
  logic   [NPORTS-1:0][1:0]    w_code;
  logic   [NPORTS-1:0]         w_cand_wr;
  logic   [NPORTS-1:0]         w_wr_ok;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: clear every word once, then serve requests
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_clear = 1'b1;
        if (r_cnt == c_last) w_state_nxt = S_RUN;
      end
      S_RUN:   ready = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Clear counter; wraps back to 0 naturally after the last word
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
  end

  // Address decode, fault priority and lowest-port-wins collision arbitration
  always_comb begin
    w_widx_full = '0;
    w_widx      = '0;
    w_code      = '0;
    w_cand_wr   = '0;
    w_wr_ok     = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_widx_full[i] = addr[i*ADDR_W+2 +: c_iw];
      w_widx[i]      = w_widx_full[i][c_aw-1:0];
      if (addr[i*ADDR_W +: 2] != 2'b00)          w_code[i] = 2'd1;
      else if ({1'b0, w_widx_full[i]} >= c_depth) w_code[i] = 2'd2;
      w_cand_wr[i] = req[i] && we[i] && (w_code[i] == 2'd0);
    end
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (j < i && w_cand_wr[i] && w_cand_wr[j] && (w_widx[i] == w_widx[j]))
          w_code[i] = 2'd3;
      end
      w_wr_ok[i] = (r_state == S_RUN) && w_cand_wr[i] && (w_code[i] == 2'd0);
    end
  end

  // Memory array: INIT clear plus byte-masked writes from winning ports
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clear) r_mem[r_cnt] <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (w_wr_ok[i] && be[i*4+k])
            r_mem[w_widx[i]][k*8 +: 8] <= wdata[i*32+k*8 +: 8];
        end
      end
    end
  end

  // Registered response path; reads sample the pre-write word (read-first)
  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_RUN) begin
      ack        <= '0;
      excpt      <= '0;
      excpt_code <= '0;
      rdata      <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        ack[i]              <= req[i];
        excpt[i]            <= req[i] && (w_code[i] != 2'd0);
        excpt_code[i*2 +: 2] <= req[i] ? w_code[i] : 2'd0;
        rdata[i*32 +: 32]   <= (req[i] && !we[i] && (w_code[i] == 2'd0))
                               ? r_mem[w_widx[i]] : 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_nport.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mem_nport
// Purpose  : Self-checking bench for arm_mem_nport (NPORTS=2, DEPTH=16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_mem_nport;

  localparam int NP = 2;
  localparam int DP = 16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        ready;
  logic [1:0]  ack;
  logic [63:0] rdata;
  logic [1:0]  excpt;
  logic [3:0]  excpt_code;

  arm_mem_nport #(.NPORTS(NP), .DEPTH(DP), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .ready(ready), .ack(ack), .rdata(rdata),
    .excpt(excpt), .excpt_code(excpt_code)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] rd;
    logic        ex;
    logic [1:0]  code;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DP];
  bit          model_ready;
  int          cyc_cnt;
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard monitor: pop the results due this cycle, everything else must be idle
  always @(negedge clk) begin
    logic [1:0] got;
    exp_t       e;
    got = 2'b00;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
      e = sbq.pop_front();
      chk("ack_cycle", cyc_cnt, e.cyc);
      chk("ack", {31'b0, ack[e.port]}, 32'd1);
      chk("rdata", rdata[e.port*32 +: 32], e.rd);
      chk("excpt", {31'b0, excpt[e.port]}, {31'b0, e.ex});
      chk("excpt_code", {30'b0, excpt_code[e.port*2 +: 2]}, {30'b0, e.code});
      got[e.port] = 1'b1;
    end
    for (int p = 0; p < NP; p++) begin
      if (!got[p]) begin
        chk("idle_ack", {31'b0, ack[p]}, 32'd0);
        chk("idle_excpt", {31'b0, excpt[p]}, 32'd0);
        chk("idle_code", {30'b0, excpt_code[p*2 +: 2]}, 32'd0);
      end
    end
  end

  // One request cycle on both ports; expectations come from the bench model
  task automatic do_cyc(input logic [1:0] rq, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] b0, input logic [3:0] b1);
    logic [31:0] aa [2];
    logic [31:0] dd [2];
    logic [3:0]  bb [2];
    logic [1:0]  cd [2];
    exp_t        e;
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1; bb[0] = b0; bb[1] = b1;
    req = rq; we = w; addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
    if (model_ready) begin
      for (int p = 0; p < NP; p++) begin
        cd[p] = 2'd0;
        if (aa[p][1:0] != 2'b00)     cd[p] = 2'd1;
        else if (aa[p][31:2] >= DP)  cd[p] = 2'd2;
        else if (p == 1 && w[1] && rq[0] && w[0] && cd[0] == 2'd0 &&
                 aa[0][31:2] == aa[1][31:2]) cd[p] = 2'd3;
        if (rq[p]) begin
          e.cyc  = cyc_cnt + 1;
          e.port = p;
          e.code = cd[p];
          e.ex   = (cd[p] != 2'd0);
          e.rd   = (cd[p] == 2'd0 && !w[p]) ? model[aa[p][5:2]] : 32'h0;
          sbq.push_back(e);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (rq[p] && w[p] && cd[p] == 2'd0)
          for (int k = 0; k < 4; k++)
            if (bb[p][k]) model[aa[p][5:2]][k*8 +: 8] = dd[p][k*8 +: 8];
      end
    end
    @(posedge clk); #1;
    req = 2'b00; we = 2'b00;
  endtask

  // Release reset (already high or just raised) and time the INIT clear,
  // while hammering writes that must be ignored
  task automatic wait_ready();
    int k;
    k = -1;
    req = 2'b11; we = 2'b11; addr = {32'h4, 32'h8}; wdata = {32'hA5A5A5A5, 32'h5A5A5A5A}; be = 8'hFF;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        k = i;
        break;
      end
    end
    req = 2'b00; we = 2'b00;
    chk("init_cycles", k, DP);
    for (int i = 0; i < DP; i++) model[i] = 32'h0;
    model_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc_cnt = 0; model_ready = 1'b0;
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_ack", {30'b0, ack}, 32'd0);
    chk("rst_excpt", {30'b0, excpt}, 32'd0);
    chk("rst_code", {28'b0, excpt_code}, 32'd0);
    chk("rst_rdata_lo", rdata[31:0], 32'd0);
    chk("rst_rdata_hi", rdata[63:32], 32'd0);
    rst_n = 1'b1;
    wait_ready();

    // all words cleared
    for (int i = 0; i < DP / 2; i++)
      do_cyc(2'b11, 2'b00, i*8, i*8+4, 0, 0, 4'h0, 4'h0);

    // write then cross-port read
    do_cyc(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4'hF, 4'h0);
    do_cyc(2'b10, 2'b00, 32'h0, 32'h10, 0, 0, 4'h0, 4'h0);

    // byte merge
    do_cyc(2'b01, 2'b01, 32'h20, 32'h0, 32'h11223344, 0, 4'hF, 4'h0);
    do_cyc(2'b01, 2'b01, 32'h20, 32'h0, 32'hAABBCCDD, 0, 4'b0101, 4'h0);
    do_cyc(2'b10, 2'b00, 32'h0, 32'h20, 0, 0, 4'h0, 4'h0);
    chk("byte_merge_model", model[8], 32'h11BB33DD);

    // be=0 write is a no-op
    do_cyc(2'b01, 2'b01, 32'h10, 32'h0, 32'hFFFFFFFF, 0, 4'h0, 4'h0);
    do_cyc(2'b01, 2'b00, 32'h10, 32'h0, 0, 0, 4'h0, 4'h0);

    // write collision, then readback
    do_cyc(2'b11, 2'b11, 32'h8, 32'h8, 32'h1, 32'h2, 4'hF, 4'hF);
    do_cyc(2'b10, 2'b00, 32'h0, 32'h8, 0, 0, 4'h0, 4'h0);

    // read-first on same word, then new data
    do_cyc(2'b01, 2'b01, 32'h30, 32'h0, 32'h55, 0, 4'hF, 4'h0);
    do_cyc(2'b11, 2'b01, 32'h30, 32'h30, 32'h66, 0, 4'hF, 4'h0);
    do_cyc(2'b11, 2'b00, 32'h30, 32'h30, 0, 0, 4'h0, 4'h0);

    // faults: misaligned, out of range, misaligned beats range
    do_cyc(2'b11, 2'b11, 32'h3, 32'h40, 32'h99, 32'h99, 4'hF, 4'hF);
    do_cyc(2'b11, 2'b00, 32'h41, 32'h3, 0, 0, 4'h0, 4'h0);
    do_cyc(2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 4'h0, 4'h0);

    // reset mid-read: the read must never be acknowledged
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h10}; rst_n = 1'b0;
    model_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack", {30'b0, ack}, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b1;
    wait_ready();
    do_cyc(2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 4'h0, 4'h0);
    do_cyc(2'b11, 2'b00, 32'h8, 32'h30, 0, 0, 4'h0, 4'h0);
    do_cyc(2'b11, 2'b00, 32'h4, 32'h0, 0, 0, 4'h0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
